// File: rtl/xmm_fixed_point_unit.sv
// rtl/xmm_fixed_point_unit.sv - multi-cycle 64-bit XMM fixed-point ALU; XMM_FXU_SATURATE_EN clamps overflowed results
module xmm_fixed_point_unit #(
  parameter int FRAC_BITS = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] fpu_res,
  output logic        res_overflow,
  output logic        res_div_zero
);

  localparam int DW = 64 + FRAC_BITS;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DW - 1);

  localparam logic [63:0] FX_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FX_MIN = 64'h8000_0000_0000_0000;
  localparam logic [DW-1:0] Q_POS_LIM = DW'(FX_MAX);
  localparam logic [DW-1:0] Q_NEG_LIM = DW'(FX_MIN);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_ABS = 3'b101;
  localparam logic [2:0] OP_MIN = 3'b110;
  localparam logic [2:0] OP_MAX = 3'b111;

`ifdef XMM_FXU_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nxt;

  logic signed [127:0] prod_q;
  logic [CW-1:0]       div_cnt;
  logic [63:0]         div_rem;
  logic [DW-1:0]       div_q;
  logic [63:0]         div_dvs;
  logic                div_neg;

  logic        accept;
  logic [64:0] sum;
  logic [63:0] sc_wrap;
  logic        sc_ovf;
  logic        sc_neg;
  logic [63:0] a_mag;
  logic [63:0] b_mag;

  logic signed [127:0] prod_sh;
  logic                mul_ovf;

  logic [64:0]   rem_sh;
  logic [64:0]   rem_sub;
  logic          q_bit;
  logic [63:0]   rem_nxt;
  logic [DW-1:0] q_nxt;
  logic          div_ovf;
  logic [63:0]   div_wrap;

  // Overflowed results either wrap or clamp toward the sign of the true result.
  function automatic logic [63:0] fix_result(input logic ovf, input logic neg, input logic [63:0] wrap);
    if (SATURATE && ovf) return neg ? FX_MIN : FX_MAX;
    return wrap;
  endfunction

  assign op_ready  = (state == S_IDLE);
  assign res_valid = (state == S_DONE);
  assign accept    = op_valid && op_ready;

  assign a_mag = op_a[63] ? (~op_a + 64'd1) : op_a;
  assign b_mag = op_b[63] ? (~op_b + 64'd1) : op_b;

  always_comb begin
    sum     = '0;
    sc_wrap = '0;
    sc_ovf  = 1'b0;
    sc_neg  = 1'b0;
    case (op_code)
      OP_ADD: begin
        sum     = {op_a[63], op_a} + {op_b[63], op_b};
        sc_wrap = sum[63:0];
        sc_ovf  = sum[64] ^ sum[63];
        sc_neg  = sum[64];
      end
      OP_SUB: begin
        sum     = {op_a[63], op_a} - {op_b[63], op_b};
        sc_wrap = sum[63:0];
        sc_ovf  = sum[64] ^ sum[63];
        sc_neg  = sum[64];
      end
      // Only the most negative value overflows, and its true negation is positive.
      OP_NEG: begin
        sc_wrap = ~op_a + 64'd1;
        sc_ovf  = (op_a == FX_MIN);
      end
      OP_ABS: begin
        sc_wrap = a_mag;
        sc_ovf  = (op_a == FX_MIN);
      end
      OP_MIN:  sc_wrap = ($signed(op_b) < $signed(op_a)) ? op_b : op_a;
      OP_MAX:  sc_wrap = ($signed(op_b) > $signed(op_a)) ? op_b : op_a;
      default: sc_wrap = '0;
    endcase
  end

  assign prod_sh = prod_q >>> FRAC_BITS;
  assign mul_ovf = !((&prod_sh[127:63]) || !(|prod_sh[127:63]));

  // Restoring division step: the remainder stays below the divisor, so 64 bits hold it.
  assign rem_sh   = {div_rem, div_q[DW-1]};
  assign rem_sub  = rem_sh - {1'b0, div_dvs};
  assign q_bit    = !rem_sub[64];
  assign rem_nxt  = q_bit ? rem_sub[63:0] : rem_sh[63:0];
  assign q_nxt    = {div_q[DW-2:0], q_bit};
  assign div_ovf  = div_neg ? (q_nxt > Q_NEG_LIM) : (q_nxt > Q_POS_LIM);
  assign div_wrap = div_neg ? (~q_nxt[63:0] + 64'd1) : q_nxt[63:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op_code == OP_MUL)                      state_nxt = S_MUL;
          else if (op_code == OP_DIV && op_b != '0)   state_nxt = S_DIV;
          else                                        state_nxt = S_DONE;
        end
      end
      S_MUL:   state_nxt = S_DONE;
      S_DIV:   if (div_cnt == DIV_LAST) state_nxt = S_DONE;
      S_DONE:  if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpu_res      <= '0;
      res_overflow <= 1'b0;
      res_div_zero <= 1'b0;
      prod_q       <= '0;
      div_cnt      <= '0;
      div_rem      <= '0;
      div_q        <= '0;
      div_dvs      <= '0;
      div_neg      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_code == OP_MUL) begin
              prod_q <= $signed({{64{op_a[63]}}, op_a}) * $signed({{64{op_b[63]}}, op_b});
            end else if (op_code == OP_DIV) begin
              if (op_b == '0) begin
                fpu_res      <= op_a[63] ? FX_MIN : FX_MAX;
                res_overflow <= 1'b0;
                res_div_zero <= 1'b1;
              end else begin
                div_cnt <= '0;
                div_rem <= '0;
                div_q   <= {a_mag, {FRAC_BITS{1'b0}}};
                div_dvs <= b_mag;
                div_neg <= op_a[63] ^ op_b[63];
              end
            end else begin
              fpu_res      <= fix_result(sc_ovf, sc_neg, sc_wrap);
              res_overflow <= sc_ovf;
              res_div_zero <= 1'b0;
            end
          end
        end
        S_MUL: begin
          fpu_res      <= fix_result(mul_ovf, prod_sh[127], prod_sh[63:0]);
          res_overflow <= mul_ovf;
          res_div_zero <= 1'b0;
        end
        S_DIV: begin
          div_rem <= rem_nxt;
          div_q   <= q_nxt;
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == DIV_LAST) begin
            fpu_res      <= fix_result(div_ovf, div_neg, div_wrap);
            res_overflow <= div_ovf;
            res_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xmm_fixed_point_unit.sv
// tb/tb_xmm_fixed_point_unit.sv - directed self-checking bench for xmm_fixed_point_unit
module tb_xmm_fixed_point_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] fpu_res;
  logic        res_overflow;
  logic        res_div_zero;

  int vectors = 0;
  int miscompares = 0;

`ifdef XMM_FXU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [63:0] FX_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FX_MIN = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  xmm_fixed_point_unit #(.FRAC_BITS(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .op_a         (op_a),
    .op_b         (op_b),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .fpu_res      (fpu_res),
    .res_overflow (res_overflow),
    .res_div_zero (res_div_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int exp_lat, input logic [63:0] exp_res, input logic exp_ovf, input logic exp_dz);
    int lat;
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid = 1'b0;
    op_a     = ~a;
    op_b     = ~b;
    lat = 1;
    while (!res_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, fpu_res, exp_res);
    chk({tag, "_ovf"}, 64'(res_overflow), 64'(exp_ovf));
    chk({tag, "_dz"}, 64'(res_div_zero), 64'(exp_dz));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_ready"}, 64'(op_ready), 64'd1);
  endtask

  initial begin
    bit seen;
    reset     = 1'b1;
    op_valid  = 1'b0;
    op_code   = 3'b000;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 64'(op_ready), 64'd1);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_res", fpu_res, 64'd0);
    chk("rst_ovf", 64'(res_overflow), 64'd0);
    chk("rst_dz", 64'(res_div_zero), 64'd0);

    run_op("add", 3'b000, 64'hC000, 64'h12000, 1, 64'h1E000, 1'b0, 1'b0);
    run_op("sub", 3'b001, 64'h10000, 64'h18000, 1, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 1'b0);
    run_op("mul", 3'b010, 64'hC000, 64'hFFFF_FFFF_FFFF_0000, 2, 64'hFFFF_FFFF_FFFE_8000, 1'b0, 1'b0);
    run_op("mul_floor", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("mul_ovf", 3'b010, FX_MAX, 64'h20000, 2, SAT ? FX_MAX : 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);

    op_valid = 1'b1; op_code = 3'b011; op_a = 64'h38000; op_b = 64'h10000;
    tick();
    op_valid = 1'b0;
    chk("div_busy", 64'(op_ready), 64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("div_busy_rr", 64'(op_ready | res_valid), 64'd0);
    repeat (80) tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    run_op("div", 3'b011, 64'h38000, 64'h10000, 80, 64'h1C000, 1'b0, 1'b0);
    run_op("div_neg", 3'b011, 64'hFFFF_FFFF_FFFC_8000, 64'h10000, 80, 64'hFFFF_FFFF_FFFE_4000, 1'b0, 1'b0);
    run_op("div_trunc", 3'b011, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD, 80, 64'hFFFF_FFFF_FFFF_D556, 1'b0, 1'b0);
    run_op("div_ovf", 3'b011, FX_MAX, 64'd1, 80, SAT ? FX_MAX : 64'hFFFF_FFFF_FFFF_8000, 1'b1, 1'b0);
    run_op("div_zero", 3'b011, 64'hFFFF_FFFF_FFFF_8000, 64'd0, 1, FX_MIN, 1'b0, 1'b1);
    run_op("div_zero_pos", 3'b011, 64'h10000, 64'd0, 1, FX_MAX, 1'b0, 1'b1);

    run_op("add_ovf", 3'b000, FX_MAX, 64'd1, 1, SAT ? FX_MAX : FX_MIN, 1'b1, 1'b0);
    run_op("sub_ovf", 3'b001, FX_MIN, 64'd1, 1, SAT ? FX_MIN : FX_MAX, 1'b1, 1'b0);
    run_op("neg", 3'b100, 64'h18000, 64'd7, 1, 64'hFFFF_FFFF_FFFE_8000, 1'b0, 1'b0);
    run_op("neg_min", 3'b100, FX_MIN, 64'd0, 1, SAT ? FX_MAX : FX_MIN, 1'b1, 1'b0);
    run_op("abs", 3'b101, 64'hFFFF_FFFF_FFFD_8000, 64'd0, 1, 64'h28000, 1'b0, 1'b0);
    run_op("abs_min", 3'b101, FX_MIN, 64'd0, 1, SAT ? FX_MAX : FX_MIN, 1'b1, 1'b0);
    run_op("min", 3'b110, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    run_op("max", 3'b111, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 1, 64'd5, 1'b0, 1'b0);

    op_valid = 1'b1; op_code = 3'b000; op_a = 64'h10000; op_b = 64'h10000;
    tick();
    op_valid = 1'b0;
    chk("bp_valid", 64'(res_valid), 64'd1);
    chk("bp_res0", fpu_res, 64'h20000);
    for (int i = 0; i < 5; i++) begin
      op_valid = i[0];
      op_code  = 3'b001;
      op_a     = 64'(i) * 64'h1111;
      tick();
      chk("bp_res", fpu_res, 64'h20000);
      chk("bp_flags", {62'd0, res_overflow, res_div_zero}, 64'd0);
      chk("bp_hold", {62'd0, op_ready, res_valid}, 64'd1);
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_release", {62'd0, op_ready, res_valid}, 64'd2);
    run_op("bp_next", 3'b111, 64'hFFFF_FFFF_FFFF_0000, 64'h8000, 1, 64'h8000, 1'b0, 1'b0);

    op_valid = 1'b1; op_code = 3'b011; op_a = 64'h38000; op_b = 64'h10000;
    tick();
    op_valid = 1'b0;
    repeat (39) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ready", 64'(op_ready), 64'd1);
    chk("abort_valid", 64'(res_valid), 64'd0);
    chk("abort_res", fpu_res, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("abort_stale", 64'(seen), 64'd0);
    run_op("post_abort", 3'b000, 64'h8000, 64'h8000, 1, 64'h10000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
